// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, instruction classes,
// opcode/funct values and the datapath select codes it drives.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_RTYPE, S_ALUIMM, S_LUI, S_MEMRD, S_MEMWR,
      S_BRANCH, S_JAL, S_J, S_JR, S_BPCINC, S_REGPCINC, S_TRAP
   } state_e;

   typedef enum logic [3:0] {
      C_RTYPE, C_JR, C_ALUIMM, C_LUI, C_LW, C_SW, C_BRANCH, C_J, C_JAL, C_BAD
   } iclass_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_PASSB = 4'b1000;

   localparam logic [2:0] SRC2_REGB  = 3'b000;
   localparam logic [2:0] SRC2_FOUR  = 3'b001;
   localparam logic [2:0] SRC2_ZERO  = 3'b010;
   localparam logic [2:0] SRC2_OFFS  = 3'b011;
   localparam logic [2:0] SRC2_EXT   = 3'b100;
   localparam logic [2:0] SRC2_UPPER = 3'b101;

   localparam logic [1:0] RA_RD  = 2'b00;
   localparam logic [1:0] RA_RT  = 2'b01;
   localparam logic [1:0] RA_R31 = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder: instruction class, valid flag, ALU op and
// zero-extend select. Zero latency, no flow control.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_e    iclass,
   output logic       valid,
   output logic       zext,
   output logic [3:0] aluop
);

   always_comb begin
      iclass = C_BAD;
      valid  = 1'b0;
      zext   = 1'b0;
      aluop  = ALU_ADD;
      case (opcode)
         OP_RTYPE: begin
            iclass = C_RTYPE;
            valid  = 1'b1;
            case (funct)
               FN_ADD:  aluop = ALU_ADD;
               FN_SUB:  aluop = ALU_SUB;
               FN_AND:  aluop = ALU_AND;
               FN_OR:   aluop = ALU_OR;
               FN_NOR:  aluop = ALU_NOR;
               FN_SLT:  aluop = ALU_SLT;
               FN_JR:   iclass = C_JR;
               default: begin
                  iclass = C_BAD;
                  valid  = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin iclass = C_ALUIMM; valid = 1'b1; aluop = ALU_ADD; end
         OP_SLTI: begin iclass = C_ALUIMM; valid = 1'b1; aluop = ALU_SLT; end
         OP_ANDI: begin iclass = C_ALUIMM; valid = 1'b1; aluop = ALU_AND; zext = 1'b1; end
         OP_ORI:  begin iclass = C_ALUIMM; valid = 1'b1; aluop = ALU_OR;  zext = 1'b1; end
         OP_LUI:  begin iclass = C_LUI;    valid = 1'b1; aluop = ALU_PASSB; end
         OP_LW:   begin iclass = C_LW;     valid = 1'b1; end
         OP_SW:   begin iclass = C_SW;     valid = 1'b1; end
         OP_BEQ,
         OP_BNE:  begin iclass = C_BRANCH; valid = 1'b1; aluop = ALU_SUB; end
         OP_J:    begin iclass = C_J;      valid = 1'b1; end
         OP_JAL:  begin iclass = C_JAL;    valid = 1'b1; end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_v2.sv
// Multicycle CPU control FSM with Moore strobes; memory states stall on mem_ready
// (wins/wreg follow mem_ready combinationally). Illegal opcodes trap until reset.
module multicycle_control_v2
   import ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W       = 4,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned MEM_HANDSHAKE = 1,
   parameter int unsigned TRAP_EN       = 1
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               aluzero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               wpc,
   output logic               wins,
   output logic               selmemaddr,
   output logic               wmem,
   output logic               selext,
   output logic               selalu1,
   output logic [2:0]         selalu2,
   output logic [ALUOP_W-1:0] aluop,
   output logic               selregwd,
   output logic [1:0]         selregaddr,
   output logic               wreg,
   output logic               illegal,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   state_e             state_q, state_d;
   iclass_e            dec_class;
   logic               dec_valid;
   logic               dec_zext;
   logic [3:0]         dec_aluop;
   logic [3:0]         aluop4;
   logic               mrdy;
   logic               illegal_q, illegal_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   ctrl_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .iclass (dec_class),
      .valid  (dec_valid),
      .zext   (dec_zext),
      .aluop  (dec_aluop)
   );

   assign mrdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

   // Outputs are forced to defaults while reset is asserted, so a reset in
   // the middle of a memory wait drops mem_req in that same cycle.
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      wpc        = 1'b0;
      wins       = 1'b0;
      selmemaddr = 1'b0;
      wmem       = 1'b0;
      selext     = 1'b0;
      selalu1    = 1'b0;
      selalu2    = SRC2_REGB;
      aluop4     = ALU_AND;
      selregwd   = 1'b0;
      selregaddr = RA_RD;
      wreg       = 1'b0;
      halted     = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               wins    = mrdy;
               if (mrdy) state_d = S_DECODE;
            end
            S_DECODE: begin
               if (!dec_valid) begin
                  state_d = (TRAP_EN != 0) ? S_TRAP : S_REGPCINC;
               end else begin
                  case (dec_class)
                     C_RTYPE:  state_d = S_RTYPE;
                     C_JR:     state_d = S_JR;
                     C_ALUIMM: state_d = S_ALUIMM;
                     C_LUI:    state_d = S_LUI;
                     C_LW:     state_d = S_MEMRD;
                     C_SW:     state_d = S_MEMWR;
                     C_BRANCH: state_d = S_BRANCH;
                     C_J:      state_d = S_J;
                     C_JAL:    state_d = S_JAL;
                     default:  state_d = (TRAP_EN != 0) ? S_TRAP : S_REGPCINC;
                  endcase
               end
            end
            S_RTYPE: begin
               wreg    = 1'b1;
               aluop4  = dec_aluop;
               state_d = S_REGPCINC;
            end
            S_ALUIMM: begin
               wreg       = 1'b1;
               selregaddr = RA_RT;
               selalu2    = SRC2_EXT;
               selext     = dec_zext;
               aluop4     = dec_aluop;
               state_d    = S_REGPCINC;
            end
            S_LUI: begin
               wreg       = 1'b1;
               selregaddr = RA_RT;
               selalu2    = SRC2_UPPER;
               aluop4     = ALU_PASSB;
               state_d    = S_REGPCINC;
            end
            S_MEMRD: begin
               mem_req    = 1'b1;
               selmemaddr = 1'b1;
               selalu2    = SRC2_EXT;
               aluop4     = ALU_ADD;
               selregwd   = 1'b1;
               selregaddr = RA_RT;
               wreg       = mrdy;
               if (mrdy) state_d = S_REGPCINC;
            end
            S_MEMWR: begin
               mem_req    = 1'b1;
               selmemaddr = 1'b1;
               selalu2    = SRC2_EXT;
               aluop4     = ALU_ADD;
               wmem       = 1'b1;
               if (mrdy) state_d = S_REGPCINC;
            end
            S_BRANCH: begin
               aluop4 = ALU_SUB;
               // opcode[0] distinguishes bne from beq
               state_d = (opcode[0] ^ aluzero) ? S_BPCINC : S_REGPCINC;
            end
            S_JAL: begin
               selalu1    = 1'b1;
               selalu2    = SRC2_FOUR;
               aluop4     = ALU_ADD;
               selregaddr = RA_R31;
               wreg       = 1'b1;
               state_d    = S_J;
            end
            S_J, S_BPCINC: begin
               selalu1 = 1'b1;
               selalu2 = SRC2_OFFS;
               aluop4  = ALU_ADD;
               wpc     = 1'b1;
               state_d = S_FETCH;
            end
            S_JR: begin
               selalu2 = SRC2_ZERO;
               aluop4  = ALU_ADD;
               wpc     = 1'b1;
               state_d = S_FETCH;
            end
            S_REGPCINC: begin
               selalu1 = 1'b1;
               selalu2 = SRC2_FOUR;
               aluop4  = ALU_ADD;
               wpc     = 1'b1;
               state_d = S_FETCH;
            end
            S_TRAP:  halted = 1'b1;
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign illegal_d = (state_q == S_DECODE) && (state_d == S_TRAP);
   assign retired_d = wpc ? retired_q + CNT_W'(1) : retired_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         retired_q <= retired_d;
      end
   end

   assign illegal = illegal_q & reset;
   assign retired = retired_q;
   assign aluop   = ALUOP_W'(aluop4);

endmodule

// File: tb/tb_multicycle_control_v2.sv
// Directed bench for multicycle_control_v2: main instance with trap enabled, a
// second instance (trap disabled, 4-bit counter) in lockstep on the same inputs.
module tb_multicycle_control_v2;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, funct;
   logic       aluzero, mem_ready;

   logic        mem_req, wpc, wins, selmemaddr, wmem, selext, selalu1;
   logic [2:0]  selalu2;
   logic [3:0]  aluop;
   logic        selregwd, wreg, illegal, halted;
   logic [1:0]  selregaddr;
   logic [15:0] retired;

   logic        mem_req_b, wpc_b, wins_b, selmemaddr_b, wmem_b, selext_b, selalu1_b;
   logic [2:0]  selalu2_b;
   logic [3:0]  aluop_b;
   logic        selregwd_b, wreg_b, illegal_b, halted_b;
   logic [1:0]  selregaddr_b;
   logic [3:0]  retired_b;

   int checks = 0;
   int errors = 0;
   int nret   = 0;

   always #5 clk = ~clk;

   multicycle_control_v2 #(.ALUOP_W(4), .CNT_W(16), .MEM_HANDSHAKE(1), .TRAP_EN(1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .aluzero(aluzero),
      .mem_ready(mem_ready), .mem_req(mem_req), .wpc(wpc), .wins(wins),
      .selmemaddr(selmemaddr), .wmem(wmem), .selext(selext), .selalu1(selalu1),
      .selalu2(selalu2), .aluop(aluop), .selregwd(selregwd), .selregaddr(selregaddr),
      .wreg(wreg), .illegal(illegal), .halted(halted), .retired(retired)
   );

   multicycle_control_v2 #(.ALUOP_W(4), .CNT_W(4), .MEM_HANDSHAKE(1), .TRAP_EN(0)) dut_b (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .aluzero(aluzero),
      .mem_ready(mem_ready), .mem_req(mem_req_b), .wpc(wpc_b), .wins(wins_b),
      .selmemaddr(selmemaddr_b), .wmem(wmem_b), .selext(selext_b), .selalu1(selalu1_b),
      .selalu2(selalu2_b), .aluop(aluop_b), .selregwd(selregwd_b), .selregaddr(selregaddr_b),
      .wreg(wreg_b), .illegal(illegal_b), .halted(halted_b), .retired(retired_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // From FETCH: present an instruction and advance to its first execute state.
   task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn);
      opcode    = op;
      funct     = fn;
      mem_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic check_ret(input string tag);
      check({tag, "_ret"}, 32'(retired), 32'(nret & 16'hFFFF));
      check({tag, "_ret_b"}, 32'(retired_b), 32'(nret & 15));
   endtask

   task automatic do_branch(input string tag, input logic [5:0] op, input logic az,
                            input logic taken);
      fetch_dec(op, 6'd0);
      aluzero = az;
      #1;
      check({tag, "_aluop"}, 32'(aluop), 32'h6);
      check({tag, "_sel2_br"}, 32'(selalu2), 32'h0);
      tick();
      check({tag, "_sel2_pc"}, 32'(selalu2), taken ? 32'h3 : 32'h1);
      check({tag, "_wpc"}, 32'(wpc), 32'h1);
      tick();
      nret++;
      check_ret(tag);
      aluzero = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; opcode = '0; funct = '0; aluzero = 1'b0; mem_ready = 1'b1;
      tick();
      tick();
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_wpc", 32'(wpc), 32'h0);
      check("rst_retired", 32'(retired), 32'h0);
      reset = 1'b1;
      #1;
      check("fetch_mem_req", 32'(mem_req), 32'h1);
      check("fetch_wins", 32'(wins), 32'h1);

      // add: FETCH, DECODE, RTYPE, REGPCINC
      fetch_dec(6'b000000, 6'b100000);
      check("add_aluop", 32'(aluop), 32'h2);
      check("add_wreg", 32'(wreg), 32'h1);
      check("add_sel2", 32'(selalu2), 32'h0);
      tick();
      check("add_wpc", 32'(wpc), 32'h1);
      check("add_ret_pre", 32'(retired), 32'h0);
      tick();
      nret = 1;
      check_ret("add");
      check("add_next_fetch", 32'(mem_req), 32'h1);

      // lw with a three-cycle memory stall
      fetch_dec(6'b100011, 6'd0);
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'b0;
         #1;
         check("lw_stall_wreg", 32'(wreg), 32'h0);
         check("lw_stall_wmem", 32'(wmem), 32'h0);
         check("lw_stall_mem_req", 32'(mem_req), 32'h1);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("lw_wreg", 32'(wreg), 32'h1);
      check("lw_selregwd", 32'(selregwd), 32'h1);
      check("lw_selmemaddr", 32'(selmemaddr), 32'h1);
      check("lw_sel2", 32'(selalu2), 32'h4);
      tick();
      check("lw_wpc", 32'(wpc), 32'h1);
      tick();
      nret++;
      check_ret("lw");

      // sw with one stall cycle
      fetch_dec(6'b101011, 6'd0);
      mem_ready = 1'b0;
      #1;
      check("sw_stall_wmem", 32'(wmem), 32'h1);
      check("sw_stall_wreg", 32'(wreg), 32'h0);
      tick();
      mem_ready = 1'b1;
      #1;
      check("sw_wmem", 32'(wmem), 32'h1);
      tick();
      check("sw_wpc", 32'(wpc), 32'h1);
      tick();
      nret++;
      check_ret("sw");

      do_branch("beq_t", 6'b000100, 1'b1, 1'b1);
      do_branch("beq_n", 6'b000100, 1'b0, 1'b0);
      do_branch("bne_n", 6'b000101, 1'b1, 1'b0);
      do_branch("bne_t", 6'b000101, 1'b0, 1'b1);

      // jal: JAL then J
      fetch_dec(6'b000011, 6'd0);
      check("jal_wreg", 32'(wreg), 32'h1);
      check("jal_regaddr", 32'(selregaddr), 32'h2);
      check("jal_sel2", 32'(selalu2), 32'h1);
      check("jal_sel1", 32'(selalu1), 32'h1);
      check("jal_wpc", 32'(wpc), 32'h0);
      tick();
      check("j_wpc", 32'(wpc), 32'h1);
      check("j_sel2", 32'(selalu2), 32'h3);
      check("j_wreg", 32'(wreg), 32'h0);
      tick();
      nret++;
      check_ret("jal");

      // jr: 3 cycles
      fetch_dec(6'b000000, 6'b001000);
      check("jr_wpc", 32'(wpc), 32'h1);
      check("jr_sel2", 32'(selalu2), 32'h2);
      check("jr_sel1", 32'(selalu1), 32'h0);
      tick();
      nret++;
      check_ret("jr");

      fetch_dec(6'b001111, 6'd0);
      check("lui_sel2", 32'(selalu2), 32'h5);
      check("lui_aluop", 32'(aluop), 32'h8);
      check("lui_regaddr", 32'(selregaddr), 32'h1);
      tick();
      tick();
      nret++;

      fetch_dec(6'b001100, 6'd0);
      check("andi_selext", 32'(selext), 32'h1);
      check("andi_aluop", 32'(aluop), 32'h0);
      check("andi_sel2", 32'(selalu2), 32'h4);
      tick();
      tick();
      nret++;

      fetch_dec(6'b001010, 6'd0);
      check("slti_selext", 32'(selext), 32'h0);
      check("slti_aluop", 32'(aluop), 32'h7);
      tick();
      tick();
      nret++;
      check_ret("imm");

      // illegal opcode: main instance traps, second instance runs it as a NOP
      fetch_dec(6'b111111, 6'd0);
      check("trap_illegal", 32'(illegal), 32'h1);
      check("trap_halted", 32'(halted), 32'h1);
      check("trap_wpc", 32'(wpc), 32'h0);
      check("nop_illegal_b", 32'(illegal_b), 32'h0);
      check("nop_wpc_b", 32'(wpc_b), 32'h1);
      tick();
      check("trap_illegal_once", 32'(illegal), 32'h0);
      check("trap_halted_hold", 32'(halted), 32'h1);
      check("nop_illegal_b2", 32'(illegal_b), 32'h0);
      tick();
      tick();
      check("trap_halted_late", 32'(halted), 32'h1);
      check("trap_wpc_late", 32'(wpc), 32'h0);
      check("trap_ret", 32'(retired), 32'(nret));
      reset = 1'b0;
      tick();
      check("trap_rst_ret", 32'(retired), 32'h0);
      check("trap_rst_ret_b", 32'(retired_b), 32'h0);
      check("trap_rst_halted", 32'(halted), 32'h0);
      reset = 1'b1;
      #1;
      check("trap_rst_fetch", 32'(mem_req), 32'h1);
      nret = 0;

      // reset during a FETCH wait
      mem_ready = 1'b0;
      #1;
      check("fwait_wins", 32'(wins), 32'h0);
      tick();
      check("fwait_hold", 32'(mem_req), 32'h1);
      reset = 1'b0;
      #1;
      check("fwait_rst_mem_req", 32'(mem_req), 32'h0);
      tick();
      check("fwait_rst_mem_req2", 32'(mem_req), 32'h0);
      check("fwait_rst_wins", 32'(wins), 32'h0);
      reset     = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("fwait_fetch_mem_req", 32'(mem_req), 32'h1);
      check("fwait_fetch_selmem", 32'(selmemaddr), 32'h0);

      // counter wrap on the 4-bit instance: 15 jumps, then one more
      opcode = 6'b000010;
      funct  = 6'd0;
      for (int i = 0; i < 15; i++) begin
         tick();
         tick();
         tick();
      end
      nret = 15;
      check_ret("pre_wrap");
      tick();
      tick();
      tick();
      nret = 16;
      check_ret("wrap");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
